// File: rtl/timer_cnt_ctrl_if.sv
// Control/status bundle between the APB timer register block and the count-enable generator.
// The register block is the master; timer_cnt_ctrl is the slave.
interface timer_cnt_ctrl_if;
    logic       timer_en;
    logic       div_en;
    logic [3:0] div_val;
    logic       halt_req;
    logic       dbg_mode;
    logic       int_en;
    logic       int_st;
    logic       cnt_en;
    logic       halt_ack;
    logic       tim_int;

    modport master (
        output timer_en,
        output div_en,
        output div_val,
        output halt_req,
        output dbg_mode,
        output int_en,
        output int_st,
        input  cnt_en,
        input  halt_ack,
        input  tim_int
    );

    modport slave (
        input  timer_en,
        input  div_en,
        input  div_val,
        input  halt_req,
        input  dbg_mode,
        input  int_en,
        input  int_st,
        output cnt_en,
        output halt_ack,
        output tim_int
    );
endinterface

// File: rtl/timer_cnt_ctrl.sv
// Count-enable generator for the 64-bit APB timer: prescaler, RUN/HALT state machine,
// debug halt acknowledge and registered interrupt line.
module timer_cnt_ctrl #(
    parameter int DIV_MAX = 8,
    parameter int PCNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    timer_cnt_ctrl_if.slave  ctrl
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [PCNT_W:0]   LIM_ONE  = {{PCNT_W{1'b0}}, 1'b1};
    localparam logic [PCNT_W-1:0] PCNT_ONE = {{(PCNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        DV_MAX   = 4'(DIV_MAX);

    state_t            state;
    state_t            next_state;
    logic [PCNT_W-1:0] pcnt;
    logic [PCNT_W-1:0] limit;
    logic [3:0]        dv;
    logic              halt_c;
    logic              halt_ack_q;
    logic              tim_int_q;
    logic              at_limit;

    assign halt_c = ctrl.halt_req & ctrl.dbg_mode;

    // Out-of-range divide ratios are clamped so the prescaler never needs more than PCNT_W bits.
    always_comb begin
        dv    = (ctrl.div_val > DV_MAX) ? DV_MAX : ctrl.div_val;
        limit = '0;
        if (ctrl.div_en && (dv != 4'd0)) begin
            limit = PCNT_W'((LIM_ONE << dv) - LIM_ONE);
        end
    end

    // >= rather than == so a shrinking limit still wraps within one period.
    assign at_limit = (pcnt >= limit);

    // timer_en=0 wins over halt_c in every state.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ctrl.timer_en) begin
                    next_state = halt_c ? HALT : RUN;
                end
            end
            RUN: begin
                if (!ctrl.timer_en) begin
                    next_state = IDLE;
                end else if (halt_c) begin
                    next_state = HALT;
                end
            end
            HALT: begin
                if (!ctrl.timer_en) begin
                    next_state = IDLE;
                end else if (!halt_c) begin
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The RUN cycle that samples halt_c still advances the prescaler, so phase survives a halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pcnt       <= '0;
            halt_ack_q <= 1'b0;
            tim_int_q  <= 1'b0;
        end else begin
            state      <= next_state;
            halt_ack_q <= (next_state == HALT);
            tim_int_q  <= ctrl.int_en & ctrl.int_st;
            if (next_state == IDLE) begin
                pcnt <= '0;
            end else if (state == RUN) begin
                pcnt <= at_limit ? '0 : (pcnt + PCNT_ONE);
            end
        end
    end

    assign ctrl.cnt_en   = (state == RUN) & at_limit;
    assign ctrl.halt_ack = halt_ack_q;
    assign ctrl.tim_int  = tim_int_q;

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Bench for timer_cnt_ctrl: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a cycle-count reference model.
module tb_timer_cnt_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    timer_cnt_ctrl_if bus ();

    timer_cnt_ctrl #(
        .DIV_MAX (8),
        .PCNT_W  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       te;
        logic       de;
        logic [3:0] dv;
        logic       hr;
        logic       dm;
        logic       ie;
        logic       is;
        logic       exp_cnt;
        logic       exp_halt;
        logic       exp_int;
    } vec_t;

    vec_t vecs [26];

    // Reference model: mode 0=off, 1=counting, 2=frozen; m_runs counts RUN cycles of the current run.
    int   m_mode = 0;
    int   m_runs = 0;
    logic m_int  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_runs <= 0;
            m_int  <= 1'b0;
        end else begin
            m_int <= bus.int_en & bus.int_st;
            if (!bus.timer_en) begin
                m_mode <= 0;
                m_runs <= 0;
            end else begin
                m_mode <= (bus.halt_req && bus.dbg_mode) ? 2 : 1;
                if (m_mode == 1) m_runs <= m_runs + 1;
            end
        end
    end

    function automatic int model_period();
        int d;
        d = (int'(bus.div_val) > 8) ? 8 : int'(bus.div_val);
        return (bus.div_en && d != 0) ? (1 << d) : 1;
    endfunction

    function automatic logic model_cnt();
        int p;
        p = model_period();
        return (m_mode == 1) && ((m_runs % p) == (p - 1));
    endfunction

    function automatic vec_t mk(input logic te, input logic de, input logic [3:0] dv,
                                input logic hr, input logic dm, input logic ie, input logic is,
                                input logic ec, input logic eh, input logic ei);
        vec_t v;
        v.te = te; v.de = de; v.dv = dv; v.hr = hr; v.dm = dm; v.ie = ie; v.is = is;
        v.exp_cnt = ec; v.exp_halt = eh; v.exp_int = ei;
        return v;
    endfunction

    task automatic check_output(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic te, input logic de, input logic [3:0] dv,
                                  input logic hr, input logic dm, input logic ie, input logic is);
        bus.timer_en = te;
        bus.div_en   = de;
        bus.div_val  = dv;
        bus.halt_req = hr;
        bus.dbg_mode = dm;
        bus.int_en   = ie;
        bus.int_st   = is;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check_output({tag, ".cnt_en"},   bus.cnt_en,   model_cnt());
        check_output({tag, ".halt_ack"}, bus.halt_ack, logic'(m_mode == 2));
        check_output({tag, ".tim_int"},  bus.tim_int,  m_int);
    endtask

    initial begin
        logic       te;
        logic       hr;
        logic       dm;
        logic [3:0] dv;
        logic       de;
        int         len;

        // te de dv  hr dm ie is | cnt halt int
        vecs[0]  = mk(1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        vecs[2]  = mk(1, 0, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        vecs[3]  = mk(1, 0, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        vecs[4]  = mk(1, 0, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 4'd0, 0, 0, 1, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 4'd0, 0, 0, 1, 0, 0, 0, 1);
        vecs[9]  = mk(0, 0, 4'd0, 0, 0, 1, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 4'd0, 0, 0, 0, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 4'd0, 0, 0, 0, 1, 0, 0, 0);
        vecs[12] = mk(0, 0, 4'd0, 0, 0, 1, 1, 0, 0, 0);
        vecs[13] = mk(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1);
        vecs[14] = mk(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 0, 4'd0, 1, 0, 0, 0, 0, 0, 0);
        vecs[16] = mk(1, 0, 4'd0, 1, 0, 0, 0, 1, 0, 0);
        vecs[17] = mk(1, 0, 4'd0, 1, 1, 0, 0, 1, 0, 0);
        vecs[18] = mk(1, 0, 4'd0, 1, 1, 0, 0, 0, 1, 0);
        vecs[19] = mk(0, 0, 4'd0, 1, 1, 0, 0, 0, 1, 0);
        vecs[20] = mk(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        vecs[21] = mk(1, 0, 4'd0, 1, 1, 0, 0, 0, 0, 0);
        vecs[22] = mk(1, 0, 4'd0, 0, 1, 0, 0, 0, 1, 0);
        vecs[23] = mk(1, 0, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        vecs[24] = mk(0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 0);
        vecs[25] = mk(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        apply_stimulus(0, 0, 4'd0, 0, 0, 0, 0);
        #12;
        check_output("reset.cnt_en",   bus.cnt_en,   1'b0);
        check_output("reset.halt_ack", bus.halt_ack, 1'b0);
        check_output("reset.tim_int",  bus.tim_int,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        end_cycle();

        for (int i = 0; i < 26; i++) begin
            apply_stimulus(vecs[i].te, vecs[i].de, vecs[i].dv, vecs[i].hr,
                           vecs[i].dm, vecs[i].ie, vecs[i].is);
            @(negedge clk);
            check_output($sformatf("vec%0d.cnt_en", i),   bus.cnt_en,   vecs[i].exp_cnt);
            check_output($sformatf("vec%0d.halt_ack", i), bus.halt_ack, vecs[i].exp_halt);
            check_output($sformatf("vec%0d.tim_int", i),  bus.tim_int,  vecs[i].exp_int);
            end_cycle();
        end

        // Divide by 8: strobe on every 8th RUN cycle, including the cycle that samples timer_en=0.
        for (int k = 0; k < 42; k++) begin
            apply_stimulus(logic'(k < 40), 1, 4'd3, 0, 0, 0, 0);
            @(negedge clk);
            check_output($sformatf("div8.k%0d.cnt_en", k), bus.cnt_en,
                         logic'(k >= 1 && k <= 40 && (k % 8) == 0));
            end_cycle();
        end

        // Divide by 4 with a 10-cycle debug halt taken when the prescaler reaches 2.
        for (int k = 0; k < 23; k++) begin
            apply_stimulus(logic'(k <= 20), 1, 4'd2, logic'(k >= 6 && k <= 15), 1, 0, 0);
            @(negedge clk);
            check_output($sformatf("halt.k%0d.cnt_en", k), bus.cnt_en,
                         logic'(k == 4 || k == 18));
            check_output($sformatf("halt.k%0d.halt_ack", k), bus.halt_ack,
                         logic'(k >= 7 && k <= 16));
            end_cycle();
        end

        // Divide by 256, reset asynchronously with the prescaler at 200, then restart.
        for (int k = 0; k < 201; k++) begin
            apply_stimulus(1, 1, 4'd8, 0, 0, 1, 1);
            end_cycle();
        end
        @(negedge clk);
        check_output("prerst.tim_int", bus.tim_int, 1'b1);
        check_output("prerst.cnt_en",  bus.cnt_en,  1'b0);
        #2;
        rst_n = 1'b0;
        apply_stimulus(0, 1, 4'd8, 0, 0, 0, 0);
        #1;
        check_output("midrst.cnt_en",   bus.cnt_en,   1'b0);
        check_output("midrst.halt_ack", bus.halt_ack, 1'b0);
        check_output("midrst.tim_int",  bus.tim_int,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        end_cycle();
        for (int k = 0; k < 258; k++) begin
            apply_stimulus(1, 1, 4'd8, 0, 0, 0, 0);
            @(negedge clk);
            check_output($sformatf("div256.k%0d.cnt_en", k), bus.cnt_en, logic'(k == 256));
            end_cycle();
        end

        // Randomized segments; divider only changes while the timer is off.
        de = 1'b1;
        dv = 4'd8;
        for (int seg = 0; seg < 25; seg++) begin
            apply_stimulus(0, de, dv, 0, 0, 0, 0);
            @(negedge clk);
            check_model($sformatf("rnd%0d.off", seg));
            end_cycle();
            de = logic'($urandom_range(0, 3) != 0);
            dv = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            apply_stimulus(0, de, dv, 0, 0, 0, 0);
            @(negedge clk);
            check_model($sformatf("rnd%0d.cfg", seg));
            end_cycle();
            len = $urandom_range(20, 300);
            for (int c = 0; c < len; c++) begin
                te = logic'($urandom_range(0, 49) != 0);
                hr = logic'($urandom_range(0, 3) == 0);
                dm = logic'($urandom_range(0, 1));
                apply_stimulus(te, de, dv, hr, dm, logic'($urandom_range(0, 1)),
                               logic'($urandom_range(0, 1)));
                @(negedge clk);
                check_model($sformatf("rnd%0d.c%0d", seg, c));
                end_cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
